// File: rtl/display_arbiter_pkg.sv
// rtl/display_arbiter_pkg.sv - shared types and constants for the display arbiter
// Purpose: arbiter state encoding and the all-digits-off blank pattern.
// Ports: none (package).
package display_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  localparam logic [7:0] BLANK_ALL = 8'hFF;

endpackage

// File: rtl/display_arbiter_lz.sv
// rtl/display_arbiter_lz.sv - leading-zero blank mask for an 8-digit hex value
// Purpose: combinational mask; bit k (1..7) set when nibbles k..7 are all zero.
// Ports:
//   value_i [31:0] in  - hex value, nibble k is digit k
//   mask_o  [7:0]  out - per-digit blank, 1 = digit off; bit 0 never set
module lz_blank_mask (
  input  logic [31:0] value_i,
  output logic [7:0]  mask_o
);

  always_comb begin
    mask_o = 8'h00;
    // Digit 0 always shows so a zero value still displays "0".
    for (int k = 1; k < 8; k++) begin
      mask_o[k] = ~|(value_i >> (4 * k));
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - two-requester arbiter driving a shared digit scanner
// Purpose: grants the scanner to one of two requesters with a minimum hold time,
//   registers the owner's value and blank mask, and divides clk into scan_clk.
// Ports:
//   clk            in  - system clock
//   rst_n          in  - asynchronous active-low reset
//   req     [1:0]  in  - per-requester display request
//   val0    [31:0] in  - requester-0 hex value
//   val1    [31:0] in  - requester-1 hex value
//   lz_en          in  - leading-zero blanking enable
//   gnt     [1:0]  out - one-hot-or-zero grant, decoded from state
//   scan_clk       out - registered divided clock, period 2*DIV
//   blank   [7:0]  out - per-digit blank, 1 = off
//   in      [31:0] out - value to the scanner
module display_arbiter
  import display_arbiter_pkg::*;
#(
  parameter int DIV  = 1000,
  parameter int HOLD = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [31:0] val0,
  input  logic [31:0] val1,
  input  logic        lz_en,
  output logic [1:0]  gnt,
  output logic        scan_clk,
  output logic [7:0]  blank,
  output logic [31:0] in
);

  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int HCW = $clog2(HOLD + 1);

  state_e           state_q, state_d;
  logic             lp_q, lp_d;
  logic [HCW-1:0]   hc_q, hc_d;
  logic [PW-1:0]    pre_q;
  logic             scan_q;
  logic [31:0]      in_q;
  logic [7:0]       blank_q;
  logic [31:0]      owner_val;
  logic [7:0]       lz_mask;

  // Prescaler: free-running, toggles scan_clk on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q  <= '0;
      scan_q <= 1'b0;
    end else if (pre_q == PW'(DIV - 1)) begin
      pre_q  <= '0;
      scan_q <= ~scan_q;
    end else begin
      pre_q  <= pre_q + PW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    lp_d    = lp_q;
    hc_d    = (hc_q == HCW'(HOLD)) ? hc_q : hc_q + HCW'(1);
    unique case (state_q)
      ST_IDLE: begin
        unique case (req)
          2'b01:   state_d = ST_OWN0;
          2'b10:   state_d = ST_OWN1;
          2'b11:   state_d = lp_q ? ST_OWN0 : ST_OWN1;
          default: state_d = ST_IDLE;
        endcase
      end
      // Owner dropping its request wins over preemption at HOLD.
      ST_OWN0: begin
        if (!req[0])                          state_d = req[1] ? ST_OWN1 : ST_IDLE;
        else if (req[1] && hc_q == HCW'(HOLD)) state_d = ST_OWN1;
      end
      ST_OWN1: begin
        if (!req[1])                          state_d = req[0] ? ST_OWN0 : ST_IDLE;
        else if (req[0] && hc_q == HCW'(HOLD)) state_d = ST_OWN0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d != state_q) begin
      hc_d = '0;
      if (state_d == ST_OWN0) lp_d = 1'b0;
      if (state_d == ST_OWN1) lp_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lp_q    <= 1'b1;
      hc_q    <= '0;
    end else begin
      state_q <= state_d;
      lp_q    <= lp_d;
      hc_q    <= hc_d;
    end
  end

  assign owner_val = (state_q == ST_OWN1) ? val1 : val0;

  lz_blank_mask u_lz (
    .value_i (owner_val),
    .mask_o  (lz_mask)
  );

  // Output registers follow the current state, so they lag gnt by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q    <= 32'h0;
      blank_q <= BLANK_ALL;
    end else if (state_q == ST_IDLE) begin
      in_q    <= 32'h0;
      blank_q <= BLANK_ALL;
    end else begin
      in_q    <= owner_val;
      blank_q <= lz_en ? lz_mask : 8'h00;
    end
  end

  assign gnt      = {state_q == ST_OWN1, state_q == ST_OWN0};
  assign scan_clk = scan_q;
  assign blank    = blank_q;
  assign in       = in_q;

endmodule
